// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit SRAM data port.
package lsu_pkg;

    localparam int LANES = 4;

    // Access size encoding as presented by the execute stage; 2'b11 is illegal.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        RESP = 2'b10
    } state_t;

    // Active-low byte enables for a store of the given size at byte offset lo.
    function automatic logic [LANES-1:0] store_ben(input size_t sz, input logic [1:0] lo);
        logic [LANES-1:0] en;
        en = '0;
        case (sz)
            SZ_B:    en = 4'b0001 << lo;
            SZ_H:    en = lo[1] ? 4'b1100 : 4'b0011;
            default: en = 4'b1111;
        endcase
        return ~en;
    endfunction

    // Right-justified store data replicated so every enabled lane sees its bytes.
    function automatic logic [31:0] store_din(input size_t sz, input logic [31:0] wd);
        logic [31:0] d;
        d = wd;
        case (sz)
            SZ_B:    d = {4{wd[7:0]}};
            SZ_H:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load data alignment: picks the addressed byte/half/word lane
// out of a 32-bit SRAM word and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  size_t       size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  lane_bytes [LANES];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_bytes[gi] = word_i[8*gi +: 8];
    end

    assign byte_sel = lane_bytes[addr_lo_i];
    assign half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    // Extend the selected lane according to the access size and signedness.
    always_comb begin
        data_o = word_i;
        case (size_i)
            SZ_B:    data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            SZ_H:    data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_sram_port.sv
// Load/store front end for the data port of the unified SRAM: one request
// outstanding at a time, SRAM strobed only in the accept cycle, load data
// captured the cycle after the strobe and returned aligned and extended.
module lsu_sram_port
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [LANES-1:0]      sram_ben,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    state_t                state_q, state_d;
    logic [1:0]            addr_lo_q;
    size_t                 size_q;
    logic                  unsigned_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_hold_q;
    logic [DATA_WIDTH-1:0] din_hold_q;

    logic                  accept;
    logic                  req_err;
    logic                  size_bad, misaligned, out_of_range;
    logic                  drive;
    size_t                 req_size_t;
    logic [DATA_WIDTH-1:0] aligned;

    assign req_ready  = (state_q == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign req_size_t = size_t'(req_size);

    // Request legality: size encoding, natural alignment, and address range.
    assign size_bad     = (req_size == 2'b11);
    assign misaligned   = ((req_size == SZ_H) && req_addr[0]) ||
                          ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
    assign out_of_range = ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign req_err      = size_bad || misaligned || out_of_range;

    // Only a legal accepted request touches the SRAM.
    assign drive = accept && !req_err;

    lsu_load_align u_align (
        .word_i     (sram_dout),
        .addr_lo_i  (addr_lo_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (aligned)
    );

    // SRAM strobes are combinational from the request; address and data hold otherwise.
    always_comb begin
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_ben  = '1;
        sram_addr = addr_hold_q;
        sram_din  = din_hold_q;
        if (drive) begin
            sram_cen  = 1'b0;
            sram_addr = req_addr[ADDR_WIDTH+1:2];
            if (req_we) begin
                sram_wen = 1'b0;
                sram_ben = store_ben(req_size_t, req_addr[1:0]);
                sram_din = store_din(req_size_t, req_wdata);
            end
        end
    end

    // Next-state and response-register update.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else if (req_we) begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                // Read data is only present this cycle; the SRAM clears it next.
                rdata_d = aligned;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Capture request attributes needed to align the load data one cycle later,
    // plus the last driven SRAM address/data so they stay put between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_lo_q   <= 2'b00;
            size_q      <= SZ_W;
            unsigned_q  <= 1'b0;
            addr_hold_q <= '0;
            din_hold_q  <= '0;
        end else if (drive) begin
            addr_lo_q   <= req_addr[1:0];
            size_q      <= req_size_t;
            unsigned_q  <= req_unsigned;
            addr_hold_q <= req_addr[ADDR_WIDTH+1:2];
            if (req_we) begin
                din_hold_q <= store_din(req_size_t, req_wdata);
            end
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_sram_port.sv
// Directed bench for lsu_sram_port with a behavioural one-cycle-latency SRAM.
module tb_lsu_sram_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        sram_cen;
    logic        sram_wen;
    logic [3:0]  sram_ben;
    logic [15:0] sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:65535];

    always #5 clk = ~clk;

    lsu_sram_port #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_ben(sram_ben),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // SRAM model: byte-masked write, registered read, output cleared when not enabled.
    always @(posedge clk) begin
        if (!sram_cen) begin
            for (int k = 0; k < 4; k++) begin
                if (!sram_wen && !sram_ben[k]) mem[sram_addr][8*k +: 8] <= sram_din[8*k +: 8];
            end
            sram_dout <= mem[sram_addr];
        end else begin
            sram_dout <= 32'h0;
        end
    end

    // Issue one request at a negedge, record accept-cycle strobes and the response.
    task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic cen, output logic wen, output logic [3:0] ben,
                           output logic [15:0] sa, output logic [31:0] din,
                           output logic v1, output logic v2,
                           output logic [31:0] rd, output logic er);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        #1;
        cen = sram_cen; wen = sram_wen; ben = sram_ben; sa = sram_addr; din = sram_din;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        v1 = resp_valid; rd = resp_rdata; er = resp_err;
        @(negedge clk);
        #1;
        v2 = resp_valid;
        if (!v1) begin rd = resp_rdata; er = resp_err; end
        $display("txn we=%0b size=%0d uns=%0b addr=%h wdata=%h -> cen=%0b ben=%b rdata=%h err=%0b",
                 we, sz, uns, addr, wd, cen, ben, rd, er);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h100; req_wdata = 32'h0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
        checks++; if (sram_cen !== 1'b1) begin failures++; $display("FAIL rst_cen got=%b exp=1", sram_cen); end
        checks++; if (sram_wen !== 1'b1) begin failures++; $display("FAIL rst_wen got=%b exp=1", sram_wen); end
        checks++; if (sram_ben !== 4'hF) begin failures++; $display("FAIL rst_ben got=%h exp=f", sram_ben); end
        checks++; if (sram_addr !== 16'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", sram_addr); end
        checks++; if (sram_din !== 32'h0) begin failures++; $display("FAIL rst_din got=%h exp=0", sram_din); end
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
        $display("txn reset released");
    endtask

    task automatic test_word();
        logic cen, wen, v1, v2, er; logic [3:0] ben; logic [15:0] sa; logic [31:0] din, rd;
        run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (cen !== 1'b0) begin failures++; $display("FAIL stw_cen got=%b exp=0", cen); end
        checks++; if (wen !== 1'b0) begin failures++; $display("FAIL stw_wen got=%b exp=0", wen); end
        checks++; if (ben !== 4'b0000) begin failures++; $display("FAIL stw_ben got=%b exp=0000", ben); end
        checks++; if (sa !== 16'h0040) begin failures++; $display("FAIL stw_addr got=%h exp=0040", sa); end
        checks++; if (din !== 32'hDEADBEEF) begin failures++; $display("FAIL stw_din got=%h exp=deadbeef", din); end
        checks++; if (v1 !== 1'b1) begin failures++; $display("FAIL stw_valid_n1 got=%b exp=1", v1); end
        checks++; if (v2 !== 1'b0) begin failures++; $display("FAIL stw_valid_n2 got=%b exp=0", v2); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL stw_resp got=%h/%b exp=0/0", rd, er); end
        run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (cen !== 1'b0 || wen !== 1'b1 || ben !== 4'hF) begin failures++; $display("FAIL ldw_strobe got=%b%b%b exp=01f", cen, wen, ben); end
        checks++; if (sa !== 16'h0040) begin failures++; $display("FAIL ldw_addr got=%h exp=0040", sa); end
        checks++; if (v1 !== 1'b0) begin failures++; $display("FAIL ldw_valid_n1 got=%b exp=0", v1); end
        checks++; if (v2 !== 1'b1) begin failures++; $display("FAIL ldw_valid_n2 got=%b exp=1", v2); end
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL ldw_rdata got=%h/%b exp=deadbeef/0", rd, er); end
    endtask

    task automatic test_byte();
        logic cen, wen, v1, v2, er; logic [3:0] ben; logic [15:0] sa; logic [31:0] din, rd;
        run_req(1'b1, 2'b00, 1'b0, 32'h103, 32'h12345680, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (ben !== 4'b0111) begin failures++; $display("FAIL stb_ben got=%b exp=0111", ben); end
        checks++; if (din !== 32'h80808080) begin failures++; $display("FAIL stb_din got=%h exp=80808080", din); end
        checks++; if (v1 !== 1'b1 || er !== 1'b0) begin failures++; $display("FAIL stb_resp got=%b/%b exp=1/0", v1, er); end
        run_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL ldb_signed got=%h exp=ffffff80", rd); end
        run_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL ldb_unsigned got=%h exp=00000080", rd); end
        run_req(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (rd !== 32'hFFFFFFBE) begin failures++; $display("FAIL ldb_lane1 got=%h exp=ffffffbe", rd); end
        run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (rd !== 32'h80ADBEEF) begin failures++; $display("FAIL ldb_merge got=%h exp=80adbeef", rd); end
    endtask

    task automatic test_half();
        logic cen, wen, v1, v2, er; logic [3:0] ben; logic [15:0] sa; logic [31:0] din, rd;
        run_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h80011234, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (sa !== 16'h0080) begin failures++; $display("FAIL sth_addr got=%h exp=0080", sa); end
        run_req(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (rd !== 32'hFFFF8001) begin failures++; $display("FAIL ldh_signed got=%h exp=ffff8001", rd); end
        run_req(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (rd !== 32'h00008001) begin failures++; $display("FAIL ldh_unsigned got=%h exp=00008001", rd); end
        run_req(1'b0, 2'b01, 1'b0, 32'h200, 32'h0, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (rd !== 32'h00001234) begin failures++; $display("FAIL ldh_low got=%h exp=00001234", rd); end
        run_req(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (cen !== 1'b1) begin failures++; $display("FAIL ldh_mis_cen got=%b exp=1", cen); end
        checks++; if (v1 !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL ldh_mis_resp got=%b/%b/%h exp=1/1/0", v1, er, rd); end
    endtask

    task automatic test_errors();
        logic cen, wen, v1, v2, er; logic [3:0] ben; logic [15:0] sa; logic [31:0] din, rd;
        run_req(1'b0, 2'b10, 1'b0, 32'h0004_0000, 32'h0, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (cen !== 1'b1 || v1 !== 1'b1 || er !== 1'b1) begin failures++; $display("FAIL err_range got=cen%b v%b e%b exp=cen1 v1 e1", cen, v1, er); end
        run_req(1'b1, 2'b11, 1'b0, 32'h0, 32'h1, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (cen !== 1'b1 || wen !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL err_size got=cen%b wen%b e%b rd%h exp=1/1/1/0", cen, wen, er, rd); end
        run_req(1'b1, 2'b10, 1'b0, 32'h102, 32'h5, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (cen !== 1'b1 || er !== 1'b1) begin failures++; $display("FAIL err_word_mis got=cen%b e%b exp=1/1", cen, er); end
        run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (rd !== 32'h80ADBEEF || er !== 1'b0) begin failures++; $display("FAIL err_no_write got=%h/%b exp=80adbeef/0", rd, er); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h80ADBEEF) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/80adbeef", i, resp_valid, resp_rdata); end
            checks++; if (req_ready !== 1'b0 || sram_cen !== 1'b1) begin failures++; $display("FAIL bp_idle[%0d] got=ready%b cen%b exp=0/1", i, req_ready, sram_cen); end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL bp_release_valid got=%b exp=1", resp_valid); end
        @(negedge clk);
        #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_after got=v%b r%b exp=0/1", resp_valid, req_ready); end
        $display("txn backpressure load addr=00000100 rdata=%h", resp_rdata);
    endtask

    task automatic test_reset_mid();
        logic cen, wen, v1, v2, er; logic [3:0] ben; logic [15:0] sa; logic [31:0] din, rd;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h200;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0 || sram_cen !== 1'b1) begin failures++; $display("FAIL rstmid_during got=v%b r%b cen%b exp=0/0/1", resp_valid, req_ready, sram_cen); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_after[%0d] got=v%b r%b exp=0/1", i, resp_valid, req_ready); end
            @(negedge clk);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, cen, wen, ben, sa, din, v1, v2, rd, er);
        checks++; if (rd !== 32'h80011234 || v2 !== 1'b1) begin failures++; $display("FAIL rstmid_reload got=%h/%b exp=80011234/1", rd, v2); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h302; req_wdata = 32'h0000A5A5;
        #1;
        checks++; if (sram_ben !== 4'b0011 || sram_din !== 32'hA5A5A5A5) begin failures++; $display("FAIL b2b_st got=%b/%h exp=0011/a5a5a5a5", sram_ben, sram_din); end
        @(negedge clk);
        req_we = 1'b0; req_unsigned = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0 || sram_cen !== 1'b1 || resp_valid !== 1'b1) begin failures++; $display("FAIL b2b_resp_cycle got=r%b cen%b v%b exp=0/1/1", req_ready, sram_cen, resp_valid); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 1'b1 || sram_cen !== 1'b0) begin failures++; $display("FAIL b2b_accept got=r%b cen%b exp=1/0", req_ready, sram_cen); end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000A5A5) begin failures++; $display("FAIL b2b_load got=%b/%h exp=1/0000a5a5", resp_valid, resp_rdata); end
        $display("txn back-to-back store/load addr=00000302 rdata=%h", resp_rdata);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        sram_dout = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
